fetch_unit: RTL

Superscalar front-end fetch stage: owns the program counter, drives both read addresses of the dual-port asynchronous-read instruction memory each cycle, and buffers the returned instruction pairs in a small circular fetch queue. Decode pops zero, one or two instructions per cycle from the queue head. A branch/jump redirect flushes the queue and restarts fetch. The block sits between the instruction memory and the decode/issue stage.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_queue.sv | 77 +++++++
 rtl/fetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch front-end: the empty-slot
// instruction value, the {inst, pc} entry layout and pointer sizing.
package fetch_unit_pkg;

    localparam logic [31:0] INST_NOP = 32'h0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FQ_PTR_WIDTH = ptr_width(4);

endpackage

// File: rtl/fetch_queue.sv
// Two-in / two-out circular buffer of fetched {inst, pc} pairs with occupancy
// count; the head and head+1 entries are presented to decode.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = ptr_width(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [1:0]            enq_count,
    input  logic [1:0]            deq_count,
    input  logic [DATA_WIDTH-1:0] enq_inst_0,
    input  logic [DATA_WIDTH-1:0] enq_inst_1,
    input  logic [ADDR_WIDTH-1:0] enq_pc_0,
    input  logic [ADDR_WIDTH-1:0] enq_pc_1,
    output logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] inst_0,
    output logic [DATA_WIDTH-1:0] inst_1,
    output logic [ADDR_WIDTH-1:0] pc_0,
    output logic [ADDR_WIDTH-1:0] pc_1,
    output logic                  valid_0,
    output logic                  valid_1
);

    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      head_1;
    logic [PTR_W-1:0]      tail_1;

    assign head_1 = head + PTR_W'(1);
    assign tail_1 = tail + PTR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_count);
            tail  <= tail + PTR_W'(enq_count);
            count <= count - CNT_W'(deq_count) + CNT_W'(enq_count);
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!flush && enq_count != 2'd0) begin
            inst_mem[tail] <= enq_inst_0;
            pc_mem[tail]   <= enq_pc_0;
        end
        if (!flush && enq_count == 2'd2) begin
            inst_mem[tail_1] <= enq_inst_1;
            pc_mem[tail_1]   <= enq_pc_1;
        end
    end

    always_comb begin
        valid_0 = (count != '0);
        valid_1 = (count > CNT_W'(1));
        inst_0  = valid_0 ? inst_mem[head]   : DATA_WIDTH'(INST_NOP);
        pc_0    = valid_0 ? pc_mem[head]     : '0;
        inst_1  = valid_1 ? inst_mem[head_1] : DATA_WIDTH'(INST_NOP);
        pc_1    = valid_1 ? pc_mem[head_1]   : '0;
    end

endmodule

// File: rtl/fetch_unit.sv
// Superscalar fetch stage: owns the PC, fetches PC/PC+4 from a dual-port
// async-read instruction memory and feeds a fetch queue drained by decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr_0,
    output logic [ADDR_WIDTH-1:0] imem_addr_1,
    input  logic [DATA_WIDTH-1:0] imem_data_0,
    input  logic [DATA_WIDTH-1:0] imem_data_1,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic [1:0]            deq_count,
    output logic [DATA_WIDTH-1:0] inst_0,
    output logic [DATA_WIDTH-1:0] inst_1,
    output logic [ADDR_WIDTH-1:0] pc_0,
    output logic [ADDR_WIDTH-1:0] pc_1,
    output logic                  valid_0,
    output logic                  valid_1
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [CNT_W-1:0]      count;
    logic [1:0]            deq;
    logic [1:0]            enq;
    logic [1:0]            q_deq;
    logic [CNT_W:0]        free;

    // Decode may ask for more than is present (or encode 3); never pop past the tail.
    function automatic logic [1:0] clamp_deq(input logic [1:0] req, input logic [CNT_W-1:0] avail);
        logic [1:0] lim;
        lim = (req == 2'd3) ? 2'd2 : req;
        return (CNT_W'(lim) > avail) ? avail[1:0] : lim;
    endfunction

    always_comb begin
        deq   = clamp_deq(deq_count, count);
        free  = (CNT_W+1)'(QUEUE_DEPTH) - {1'b0, count} + (CNT_W+1)'(deq);
        enq   = 2'd0;
        q_deq = deq;
        if (redirect_valid) begin
            q_deq = 2'd0;
        end else if (free >= (CNT_W+1)'(2)) begin
            enq = 2'd2;
        end else if (free == (CNT_W+1)'(1)) begin
            enq = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~ADDR_WIDTH'(3);
        end else begin
            pc <= pc + ADDR_WIDTH'({enq, 2'b00});
        end
    end

    assign imem_addr_0 = pc;
    assign imem_addr_1 = pc + ADDR_WIDTH'(4);

    fetch_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .enq_count  (enq),
        .deq_count  (q_deq),
        .enq_inst_0 (imem_data_0),
        .enq_inst_1 (imem_data_1),
        .enq_pc_0   (imem_addr_0),
        .enq_pc_1   (imem_addr_1),
        .count      (count),
        .inst_0     (inst_0),
        .inst_1     (inst_1),
        .pc_0       (pc_0),
        .pc_1       (pc_1),
        .valid_0    (valid_0),
        .valid_1    (valid_1)
    );

endmodule
